// File: rtl/pp_seg7_scan.sv
// -----------------------------------------------------------------------------
// pp_seg7_scan
// Four-digit, common-anode seven-segment scanner for the ping-pong counter.
// The display is time multiplexed. Digits 1..0 show the 4-bit count as two
// decimal digits (00-15). Digits 3..2 show a direction glyph.
// Each scan frame starts when the digit index wraps from 3 to 0. The inputs are
// captured into a snapshot at that point only, so a frame is never torn.
//
// Parameters
//   DIV_BITS   width of the refresh counter; each digit stays lit for
//              2^DIV_BITS clk cycles
//
// Ports
//   clk        system clock; all state changes on posedge
//   rst        synchronous reset, active-high, overrides everything
//   value      count to display (0-15)
//   direction  0 = counting up, 1 = counting down
//   hold       1 = keep the current snapshot at frame start (scan continues)
//   an         digit anodes, active-low, one-hot-zero
//   seg        segments {g,f,e,d,c,b,a}, active-low
//
// Optional feature
//   PPS_LZ_BLANK_EN  when defined, the tens digit is blanked for values 0-9.
//                    Its anode is still driven.
// -----------------------------------------------------------------------------
module pp_seg7_scan #(
    parameter int DIV_BITS = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] value,
    input  logic       direction,
    input  logic       hold,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_UP    = 7'b1011100;
    localparam logic [6:0] SEG_DOWN  = 7'b1100011;

    logic [DIV_BITS-1:0] cnt_q, cnt_d;
    logic [1:0]          idx_q, idx_d;
    logic [3:0]          snap_val_q, snap_val_d;
    logic                snap_dir_q, snap_dir_d;

    logic digit_adv;
    logic frame_start;

    assign digit_adv   = &cnt_q;
    assign frame_start = digit_adv && (idx_q == 2'd3);

    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        snap_val_d = snap_val_q;
        snap_dir_d = snap_dir_q;
        if (digit_adv) begin
            idx_d = idx_q + 2'd1;
        end
        if (frame_start && !hold) begin
            snap_val_d = value;
            snap_dir_d = direction;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            snap_val_q <= 4'd0;
            snap_dir_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_val_q <= snap_val_d;
            snap_dir_q <= snap_dir_d;
        end
    end

    function automatic logic [6:0] digit_pattern(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = SEG_BLANK;
        endcase
        return p;
    endfunction

    logic       tens;
    logic [3:0] ones;

    // The input never exceeds 15, so one compare-and-subtract is enough to
    // split it into tens and ones.
    assign tens = (snap_val_q >= 4'd10);
    assign ones = tens ? (snap_val_q - 4'd10) : snap_val_q;

    always_comb begin
        an  = 4'b1111;
        seg = SEG_BLANK;
        case (idx_q)
            2'd0: begin
                an  = 4'b1110;
                seg = digit_pattern(ones);
            end
            2'd1: begin
                an = 4'b1101;
`ifdef PPS_LZ_BLANK_EN
                seg = tens ? digit_pattern(4'd1) : SEG_BLANK;
`else
                seg = digit_pattern({3'b000, tens});
`endif
            end
            2'd2: begin
                an  = 4'b1011;
                seg = snap_dir_q ? SEG_DOWN : SEG_UP;
            end
            default: begin
                an  = 4'b0111;
                seg = snap_dir_q ? SEG_DOWN : SEG_UP;
            end
        endcase
    end

endmodule
